ex_stage_pipe: RTL and testbench

//  Parametrised execute stage with built-in EX/MEM pipeline register for the 5-stage MIPS core.

---
 rtl/ex_stage_pipe.sv | 216 +++++++++++++++++++++
 tb/tb_ex_stage_pipe.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage_pipe.sv
// Execute stage of the 5-stage MIPS core with its EX/MEM pipeline register:
// operand forwarding, ALU, branch-target adder and an iterative shift-and-add MULT unit.
module ex_stage_pipe #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int MUL_EN = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic              stall_in,
   input  logic              flush,
   input  logic [DATA_W-1:0] npc,
   input  logic [DATA_W-1:0] reg_rs,
   input  logic [DATA_W-1:0] reg_rt,
   input  logic [DATA_W-1:0] sign_ext,
   input  logic [1:0]        wb_ctl,
   input  logic [2:0]        m_ctl,
   input  logic [3:0]        ex_ctl,
   input  logic [REG_AW-1:0] instr_20_16,
   input  logic [REG_AW-1:0] instr_15_11,
   input  logic [1:0]        fwd_a,
   input  logic [1:0]        fwd_b,
   input  logic [DATA_W-1:0] mem_fwd_data,
   input  logic [DATA_W-1:0] wb_fwd_data,
   output logic              ex_busy,
   output logic              out_valid,
   output logic [1:0]        wb_ctlout,
   output logic [2:0]        m_ctlout,
   output logic [DATA_W-1:0] add_result,
   output logic [DATA_W-1:0] alu_result,
   output logic              zero,
   output logic [DATA_W-1:0] rdata2out,
   output logic [REG_AW-1:0] five_bit_muxout
);

   localparam int CNT_W = $clog2(DATA_W) + 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} mul_state_e;
   typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL} alu_op_e;

   function automatic logic [DATA_W-1:0] alu_calc(input alu_op_e op,
                                                  input logic signed [DATA_W-1:0] a,
                                                  input logic signed [DATA_W-1:0] b);
      case (op)
         OP_SUB:  return a - b;
         OP_AND:  return a & b;
         OP_OR:   return a | b;
         OP_SLT:  return (a < b) ? DATA_W'(1) : '0;
         default: return a + b;
      endcase
   endfunction

   mul_state_e               state_q;
   logic                     busy_q;
   logic [CNT_W-1:0]         cnt_q;
   logic [DATA_W-1:0]        mcand_q, mplier_q, prod_q, prod_d;
   logic [1:0]               mwb_q;
   logic [2:0]               mm_q;
   logic [REG_AW-1:0]        mdest_q;
   logic [DATA_W-1:0]        mbr_q, mrd2_q;

   logic                     vld_q, zero_q;
   logic [1:0]               wb_q;
   logic [2:0]               m_q;
   logic [DATA_W-1:0]        add_q, alu_q, rd2_q;
   logic [REG_AW-1:0]        dest_q;

   alu_op_e                  op;
   logic signed [DATA_W-1:0] op_a, op_b;
   logic [DATA_W-1:0]        b_fwd, alu_d, br_d;
   logic [REG_AW-1:0]        dest_d;
   logic                     is_mul;

   always_comb begin
      op = OP_ADD;
      case (ex_ctl[1:0])
         2'b01: op = OP_SUB;
         2'b10: begin
            case (sign_ext[5:0])
               6'h22: op = OP_SUB;
               6'h24: op = OP_AND;
               6'h25: op = OP_OR;
               6'h2A: op = OP_SLT;
               6'h18: if (MUL_EN != 0) op = OP_MUL;
               default: op = OP_ADD;
            endcase
         end
         2'b11: op = OP_OR;
         default: op = OP_ADD;
      endcase
   end

   // Forwarding: 01 selects MEM/WB, 10 selects EX/MEM, 00 and 11 the register file.
   always_comb begin
      case (fwd_a)
         2'b01:   op_a = wb_fwd_data;
         2'b10:   op_a = mem_fwd_data;
         default: op_a = reg_rs;
      endcase
      case (fwd_b)
         2'b01:   b_fwd = wb_fwd_data;
         2'b10:   b_fwd = mem_fwd_data;
         default: b_fwd = reg_rt;
      endcase
      op_b   = ex_ctl[3] ? sign_ext : b_fwd;
      alu_d  = alu_calc(op, op_a, op_b);
      br_d   = npc + (sign_ext << 2);
      dest_d = ex_ctl[2] ? instr_15_11 : instr_20_16;
      is_mul = (op == OP_MUL);
      prod_d = mplier_q[0] ? prod_q + mcand_q : prod_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         busy_q   <= 1'b0;
         cnt_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         prod_q   <= '0;
         mwb_q    <= '0;
         mm_q     <= '0;
         mdest_q  <= '0;
         mbr_q    <= '0;
         mrd2_q   <= '0;
         vld_q    <= 1'b0;
         wb_q     <= '0;
         m_q      <= '0;
         add_q    <= '0;
         alu_q    <= '0;
         zero_q   <= 1'b0;
         rd2_q    <= '0;
         dest_q   <= '0;
      end else if (flush) begin
         vld_q   <= 1'b0;
         wb_q    <= '0;
         m_q     <= '0;
         state_q <= S_IDLE;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (!stall_in) begin
                  if (in_valid && !is_mul) begin
                     vld_q  <= 1'b1;
                     wb_q   <= wb_ctl;
                     m_q    <= m_ctl;
                     add_q  <= br_d;
                     alu_q  <= alu_d;
                     zero_q <= (alu_d == '0);
                     rd2_q  <= b_fwd;
                     dest_q <= dest_d;
                  end else begin
                     vld_q <= 1'b0;
                     wb_q  <= '0;
                     m_q   <= '0;
                  end
                  // Everything the product needs is captured here; ID/EX may change while busy.
                  if (in_valid && is_mul) begin
                     state_q  <= S_RUN;
                     busy_q   <= 1'b1;
                     cnt_q    <= '0;
                     prod_q   <= '0;
                     mcand_q  <= op_a;
                     mplier_q <= op_b;
                     mwb_q    <= wb_ctl;
                     mm_q     <= m_ctl;
                     mdest_q  <= dest_d;
                     mbr_q    <= br_d;
                     mrd2_q   <= b_fwd;
                  end
               end
            end
            S_RUN: begin
               prod_q   <= prod_d;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               cnt_q    <= cnt_q + 1'b1;
               if (cnt_q == CNT_W'(DATA_W - 1)) state_q <= S_DONE;
               if (!stall_in) begin
                  vld_q <= 1'b0;
                  wb_q  <= '0;
                  m_q   <= '0;
               end
            end
            S_DONE: begin
               if (!stall_in) begin
                  vld_q   <= 1'b1;
                  wb_q    <= mwb_q;
                  m_q     <= mm_q;
                  add_q   <= mbr_q;
                  alu_q   <= prod_q;
                  zero_q  <= (prod_q == '0);
                  rd2_q   <= mrd2_q;
                  dest_q  <= mdest_q;
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign ex_busy         = busy_q;
   assign out_valid       = vld_q;
   assign wb_ctlout       = wb_q;
   assign m_ctlout        = m_q;
   assign add_result      = add_q;
   assign alu_result      = alu_q;
   assign zero            = zero_q;
   assign rdata2out       = rd2_q;
   assign five_bit_muxout = dest_q;

endmodule

// File: tb/tb_ex_stage_pipe.sv
// Scoreboard bench for ex_stage_pipe: expectations queued at issue, compared on each EX/MEM load.
module tb_ex_stage_pipe;

   logic        clk = 1'b0;
   logic        reset, in_valid, stall_in, flush;
   logic [31:0] npc, reg_rs, reg_rt, sign_ext, mem_fwd_data, wb_fwd_data;
   logic [1:0]  wb_ctl, fwd_a, fwd_b;
   logic [2:0]  m_ctl;
   logic [3:0]  ex_ctl;
   logic [4:0]  instr_20_16, instr_15_11;
   logic        ex_busy, out_valid, zero;
   logic [1:0]  wb_ctlout;
   logic [2:0]  m_ctlout;
   logic [31:0] add_result, alu_result, rdata2out;
   logic [4:0]  five_bit_muxout;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [31:0] alu;
      logic [31:0] add;
      logic        zero;
      logic [4:0]  dest;
      logic [1:0]  wb;
      logic [2:0]  m;
      logic [31:0] rd2;
   } exp_t;
   exp_t sb[$];

   ex_stage_pipe #(.DATA_W(32), .REG_AW(5), .MUL_EN(1)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .stall_in(stall_in), .flush(flush),
      .npc(npc), .reg_rs(reg_rs), .reg_rt(reg_rt), .sign_ext(sign_ext),
      .wb_ctl(wb_ctl), .m_ctl(m_ctl), .ex_ctl(ex_ctl),
      .instr_20_16(instr_20_16), .instr_15_11(instr_15_11),
      .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_fwd_data(mem_fwd_data), .wb_fwd_data(wb_fwd_data),
      .ex_busy(ex_busy), .out_valid(out_valid), .wb_ctlout(wb_ctlout), .m_ctlout(m_ctlout),
      .add_result(add_result), .alu_result(alu_result), .zero(zero),
      .rdata2out(rdata2out), .five_bit_muxout(five_bit_muxout)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      case (f)
         6'h22:   return a - b;
         6'h24:   return a & b;
         6'h25:   return a | b;
         6'h2A:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         default: return a + b;
      endcase
   endfunction

   task automatic push_exp(input logic [31:0] exp_alu, input logic [31:0] exp_rd2);
      exp_t e;
      e.alu  = exp_alu;
      e.add  = npc + (sign_ext << 2);
      e.zero = (exp_alu == 32'd0);
      e.dest = ex_ctl[2] ? instr_15_11 : instr_20_16;
      e.wb   = wb_ctl;
      e.m    = m_ctl;
      e.rd2  = exp_rd2;
      sb.push_back(e);
   endtask

   task automatic fire(input logic [31:0] exp_alu, input logic [31:0] exp_rd2, input bit push);
      if (push) push_exp(exp_alu, exp_rd2);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic set_r(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      ex_ctl   = 4'b0110;
      fwd_a    = 2'b00;
      fwd_b    = 2'b00;
      reg_rs   = a;
      reg_rt   = b;
      sign_ext = {26'h0, f};
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // Scoreboard: an EX/MEM load happens on any edge without reset, flush or stall.
   initial begin
      exp_t e;
      logic m_st, m_fl, m_rs;
      forever begin
         @(posedge clk);
         m_st = stall_in;
         m_fl = flush;
         m_rs = reset;
         #1;
         if (!m_st && !m_fl && !m_rs && out_valid) begin
            if (sb.size() == 0) check("sb_underflow", 1, 0);
            else begin
               e = sb.pop_front();
               check("alu_result", alu_result, e.alu);
               check("add_result", add_result, e.add);
               check("zero", zero, e.zero);
               check("dest", five_bit_muxout, e.dest);
               check("wb_ctlout", wb_ctlout, e.wb);
               check("m_ctlout", m_ctlout, e.m);
               check("rdata2out", rdata2out, e.rd2);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [5:0]  fl [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
      logic [5:0]  f;
      logic [31:0] a, b;
      int n, bad;

      reset = 1'b1; in_valid = 1'b0; stall_in = 1'b0; flush = 1'b0;
      npc = 32'h40; reg_rs = 0; reg_rt = 0; sign_ext = 0;
      wb_ctl = 2'b11; m_ctl = 3'b010; ex_ctl = 0;
      instr_20_16 = 5'd9; instr_15_11 = 5'd3;
      fwd_a = 0; fwd_b = 0; mem_fwd_data = 32'h55; wb_fwd_data = 32'h66;
      tick(); tick();
      check("rst_out_valid", out_valid, 0);
      check("rst_ex_busy", ex_busy, 0);
      check("rst_alu", alu_result, 0);
      check("rst_add", add_result, 0);
      check("rst_ctl", {wb_ctlout, m_ctlout}, 0);
      check("rst_misc", {zero, rdata2out, five_bit_muxout}, 0);
      reset = 1'b0;

      // ADD 5+7, then a bubble
      set_r(6'h20, 32'd5, 32'd7);
      fire(32'd12, 32'd7, 1);
      tick();
      check("bubble_vld", out_valid, 0);
      check("bubble_ctl", {wb_ctlout, m_ctlout}, 0);

      // SUB 9-9 via alu_op 01, branch target
      ex_ctl = 4'b0001; reg_rs = 9; reg_rt = 9; npc = 32'h100; sign_ext = 32'd4;
      fire(32'd0, 32'd9, 1);
      npc = 32'h40;

      // SLT with forwarding, then swapped
      set_r(6'h2A, 32'h0, 32'h0);
      mem_fwd_data = 32'd3; wb_fwd_data = 32'hFFFF_FFFF;
      fwd_a = 2'b10; fwd_b = 2'b01;
      fire(32'd0, 32'hFFFF_FFFF, 1);
      fwd_a = 2'b01; fwd_b = 2'b10;
      fire(32'd1, 32'd3, 1);

      // fwd 11 selects register file; unknown funct is ADD
      set_r(6'h3F, 32'd11, 32'd22);
      fwd_a = 2'b11; fwd_b = 2'b11;
      fire(32'd33, 32'd22, 1);

      // ORI (alu_op 11, imm, dest rt) and ADDI negative immediate
      ex_ctl = 4'b1011; reg_rs = 32'hF0; reg_rt = 32'h77; sign_ext = 32'h0F; fwd_a = 0; fwd_b = 0;
      wb_ctl = 2'b01; m_ctl = 3'b100;
      fire(32'hFF, 32'h77, 1);
      ex_ctl = 4'b1000; reg_rs = 32'd100; sign_ext = 32'hFFFF_FFFC;
      fire(32'd96, 32'h77, 1);
      wb_ctl = 2'b11; m_ctl = 3'b010;

      // back-to-back random R-type ops
      for (int i = 0; i < 10; i++) begin
         f = fl[$urandom_range(0, 4)];
         a = $urandom;
         b = (i == 3) ? a : $urandom;
         set_r(f, a, b);
         sign_ext = ({$urandom} & 32'hFFFF_FFC0) | {26'h0, f};
         instr_15_11 = 5'($urandom); instr_20_16 = 5'($urandom);
         fire(model(f, a, b), b, 1);
      end

      // stall: outputs frozen while a new instruction waits
      set_r(6'h20, 32'd10, 32'd20);
      wb_ctl = 2'b10; m_ctl = 3'b001;
      fire(32'd30, 32'd20, 1);
      stall_in = 1'b1;
      ex_ctl = 4'b0001; reg_rs = 32'd50; reg_rt = 32'd8; wb_ctl = 2'b01;
      push_exp(32'd42, 32'd8);
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall_alu", alu_result, 32'd30);
         check("stall_vld", out_valid, 1);
         check("stall_wb", wb_ctlout, 2'b10);
      end
      stall_in = 1'b0;
      tick();
      in_valid = 1'b0;
      check("stall_release", alu_result, 32'd42);

      // MULT 0x0001_0003 x 6
      set_r(6'h18, 32'h0001_0003, 32'd6);
      wb_ctl = 2'b11; m_ctl = 3'b000;
      fire(32'h0006_0012, 32'd6, 1);
      reg_rs = 32'hDEAD_BEEF; reg_rt = 32'h1234; sign_ext = 32'h20;
      n = 0; bad = 0;
      while (ex_busy && n < 40) begin
         if (out_valid) bad++;
         n++;
         tick();
      end
      check("mul_busy_cycles", n, 33);
      check("mul_run_bubbles", bad, 0);
      check("mul_out_valid", out_valid, 1);
      check("mul_product", alu_result, 32'h0006_0012);
      tick();

      // MULT aborted by flush in RUN cycle 10
      set_r(6'h18, 32'd7, 32'd9);
      fire(32'd63, 32'd9, 0);
      repeat (9) tick();
      check("flush_pre_busy", ex_busy, 1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush_busy", ex_busy, 0);
      check("flush_vld", out_valid, 0);
      bad = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (out_valid || ex_busy) bad++;
      end
      check("flush_no_product", bad, 0);

      // flush wins over stall
      set_r(6'h20, 32'd1, 32'd2);
      fire(32'd3, 32'd2, 1);
      stall_in = 1'b1; flush = 1'b1;
      tick();
      stall_in = 1'b0; flush = 1'b0;
      check("flush_stall_vld", out_valid, 0);
      check("flush_stall_ctl", {wb_ctlout, m_ctlout}, 0);

      tick(); tick();
      check("sb_drained", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
